// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared defaults, queue-entry record and sizing helper for the fetch queue
package fetch_queue_pkg;
  localparam int XLEN_DEF = 32;
  localparam int AW_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int RESET_PC_DEF = 0;
  typedef struct packed {
    logic [XLEN_DEF-1:0] instr;
    logic [AW_DEF-1:0]   pc;
  } fq_entry_t;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetched entries with flush and occupancy count
module fetch_fifo #(
  parameter int W = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [PW:0]   r_cnt;
  logic          w_pop, w_push;
  assign w_pop = pop && (r_cnt != '0);
  assign w_push = push && ((r_cnt != (PW+1)'(DEPTH)) || w_pop);
  assign dout = r_mem[r_rd];
  assign valid = r_cnt != '0;
  assign count = r_cnt;
  // pointers and count; flush empties the queue in one edge
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      r_wr <= w_push ? r_wr + 1'b1 : r_wr;
      r_rd <= w_pop ? r_rd + 1'b1 : r_rd;
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
  // entry storage; contents are don't-care until counted in
  always_ff @(posedge clock) begin
    if (w_push && !flush) r_mem[r_wr] <= din;
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: credit-based instruction fetch from synchronous RAM into a decode queue
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW = AW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
  input  logic                     clock,
  input  logic                     clear,
  output logic                     imem_en,
  output logic [AW-1:0]            imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirect_pc,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [XLEN-1:0]          id_instr,
  output logic [AW-1:0]            id_pc,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int LW = lvl_w(DEPTH);
  logic [AW-1:0]      r_pc, r_inflight_pc;
  logic               r_inflight;
  logic [LW:0]        w_used;
  logic               w_push, w_pop, w_valid;
  logic [XLEN+AW-1:0] w_head;
  // a slot is reserved for every request still in flight, so pushes never overflow
  assign w_used = {1'b0, level} + {{LW{1'b0}}, r_inflight};
  assign imem_en = !clear && !redirect && (w_used < (LW+1)'(DEPTH));
  assign imem_addr = r_pc;
  assign w_push = r_inflight && !redirect;
  assign w_pop = w_valid && id_ready && !redirect;
  assign id_valid = w_valid;
  assign {id_instr, id_pc} = w_valid ? w_head : '0;
  fetch_fifo #(.W(XLEN + AW), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .clear (clear),
    .flush (redirect),
    .push  (w_push),
    .pop   (w_pop),
    .din   ({imem_rdata, r_inflight_pc}),
    .dout  (w_head),
    .valid (w_valid),
    .count (level)
  );
  // fetch PC and in-flight tracking; redirect overrides issue and kills the pending response
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect) begin
      r_pc <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= imem_en;
      r_pc <= imem_en ? r_pc + 1'b1 : r_pc;
      r_inflight_pc <= imem_en ? r_pc : r_inflight_pc;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: vector table plus scoreboard for fetch_queue
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  typedef struct packed {
    logic       rd;
    logic [7:0] rpc;
    logic       rdy;
    logic       en;
    logic [7:0] addr;
    logic       v;
    logic [7:0] pc;
    logic [2:0] lvl;
  } vec_t;
  logic clock = 1'b0;
  logic clear, imem_en, redirect, id_ready, id_valid;
  logic [7:0] imem_addr, redirect_pc, id_pc;
  logic [31:0] imem_rdata, id_instr;
  logic [2:0] level;
  int n_chk = 0;
  int n_fail = 0;
  fq_entry_t sb[$];
  fq_entry_t e;
  vec_t tv[22];
  fetch_queue dut (
    .clock       (clock),
    .clear       (clear),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .level       (level)
  );
  always #5 clock = ~clock;
  // synchronous instruction RAM: RAM[i] = i + 0x100
  always @(posedge clock) begin
    if (imem_en) imem_rdata <= 32'h100 + {24'h0, imem_addr};
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // scoreboard: expect each issued fetch back at decode in order, dropped on redirect/clear
  always @(negedge clock) begin
    if (!clear) begin
      if (redirect) sb.delete();
      else begin
        if (id_valid && id_ready) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_empty: got pc %0h expected no valid instruction", id_pc);
          end else begin
            e = sb.pop_front();
            chk("sb_instr", 64'(id_instr), 64'(e.instr));
            chk("sb_pc", 64'(id_pc), 64'(e.pc));
          end
        end
        if (imem_en) sb.push_back('{instr: 32'h100 + {24'h0, imem_addr}, pc: imem_addr});
      end
    end
  end
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  initial begin
    int reqs, vcnt;
    //         rd  rpc    rdy en  addr   v   pc     lvl
    tv[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 3'd0};
    tv[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00, 3'd0};
    tv[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1, 8'h00, 3'd1};
    tv[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b1, 8'h01, 3'd1};
    tv[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 1'b1, 8'h02, 3'd1};
    tv[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 1'b1, 8'h03, 3'd1};
    tv[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h06, 1'b1, 8'h03, 3'd2};
    tv[7]  = '{1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 3'd3};
    tv[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 3'd0};
    tv[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0, 8'h00, 3'd0};
    tv[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 1'b1, 8'h40, 3'd1};
    tv[11] = '{1'b1, 8'hFE, 1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 3'd1};
    tv[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hFE, 1'b0, 8'h00, 3'd0};
    tv[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 3'd0};
    tv[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 8'hFE, 3'd1};
    tv[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b1, 8'hFF, 3'd1};
    tv[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1, 8'h00, 3'd1};
    tv[17] = '{1'b1, 8'h10, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 3'd1};
    tv[18] = '{1'b1, 8'h20, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0};
    tv[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 1'b0, 8'h00, 3'd0};
    tv[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h21, 1'b0, 8'h00, 3'd0};
    tv[21] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b1, 8'h20, 3'd1};
    clear = 1'b1;
    redirect = 1'b0;
    redirect_pc = 8'h00;
    id_ready = 1'b1;
    @(negedge clock);
    chk("rst_en", 64'(imem_en), 64'd0);
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_instr", 64'(id_instr), 64'd0);
    chk("rst_pc", 64'(id_pc), 64'd0);
    cyc();
    clear = 1'b0;
    for (int i = 0; i < 22; i++) begin
      redirect = tv[i].rd;
      redirect_pc = tv[i].rpc;
      id_ready = tv[i].rdy;
      @(negedge clock);
      chk($sformatf("v%0d_en", i), 64'(imem_en), 64'(tv[i].en));
      if (tv[i].en) chk($sformatf("v%0d_addr", i), 64'(imem_addr), 64'(tv[i].addr));
      chk($sformatf("v%0d_valid", i), 64'(id_valid), 64'(tv[i].v));
      if (tv[i].v) chk($sformatf("v%0d_pc", i), 64'(id_pc), 64'(tv[i].pc));
      chk($sformatf("v%0d_level", i), 64'(level), 64'(tv[i].lvl));
      cyc();
    end
    redirect = 1'b0;
    clear = 1'b1;
    sb.delete();
    id_ready = 1'b0;
    @(negedge clock);
    cyc();
    clear = 1'b0;
    reqs = 0;
    repeat (8) begin
      @(negedge clock);
      reqs += int'(imem_en);
      cyc();
    end
    chk("fill_reqs", 64'(reqs), 64'd4);
    @(negedge clock);
    chk("fill_level", 64'(level), 64'd4);
    chk("fill_en", 64'(imem_en), 64'd0);
    chk("fill_valid", 64'(id_valid), 64'd1);
    chk("fill_hold_pc", 64'(id_pc), 64'd0);
    chk("fill_hold_instr", 64'(id_instr), 64'h100);
    cyc();
    id_ready = 1'b1;
    vcnt = 0;
    repeat (12) begin
      @(negedge clock);
      vcnt += int'(id_valid);
      cyc();
    end
    chk("drain_valid_cycles", 64'(vcnt), 64'd12);
    id_ready = 1'b0;
    repeat (8) cyc();
    @(negedge clock);
    chk("refill_level", 64'(level), 64'd4);
    #1;
    clear = 1'b1;
    sb.delete();
    #1;
    chk("aclr_en", 64'(imem_en), 64'd0);
    chk("aclr_valid", 64'(id_valid), 64'd0);
    chk("aclr_level", 64'(level), 64'd0);
    chk("aclr_instr", 64'(id_instr), 64'd0);
    chk("aclr_pc", 64'(id_pc), 64'd0);
    cyc();
    clear = 1'b0;
    id_ready = 1'b1;
    @(negedge clock);
    chk("restart_en", 64'(imem_en), 64'd1);
    chk("restart_addr", 64'(imem_addr), 64'd0);
    chk("restart_valid0", 64'(id_valid), 64'd0);
    cyc();
    @(negedge clock);
    chk("restart_valid1", 64'(id_valid), 64'd0);
    cyc();
    @(negedge clock);
    chk("restart_valid2", 64'(id_valid), 64'd1);
    chk("restart_pc", 64'(id_pc), 64'd0);
    chk("restart_instr", 64'(id_instr), 64'h100);
    repeat (4) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
